// File: rtl/md5_pkg.sv
// ----------------------------------------------------------------------------
// md5_pkg: alphabet, state encoding and guess-interface widths. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package md5_pkg;

  localparam logic [7:0] CHAR_MIN = 8'h61;
  localparam logic [7:0] CHAR_MAX = 8'h7A;
  localparam int         RADIX    = int'(CHAR_MAX) - int'(CHAR_MIN) + 1;

  localparam int GUESS_DATA_W  = 128;
  localparam int GUESS_LEN_W   = 5;
  localparam int GUESS_COUNT_W = 32;
  localparam int STRIDE_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/guess_digit_add.sv
// ----------------------------------------------------------------------------
// guess_digit_add: one base-RADIX digit plus addend and carry-in. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module guess_digit_add #(
  parameter int DIGIT_W = 5,
  parameter int RADIX   = 26,
  parameter int ADD_W   = 3
) (
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic [ADD_W-1:0]   addend_i,
  input  logic               carry_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_o
);

  localparam int SUM_W = DIGIT_W + ADD_W + 1;

  logic [SUM_W-1:0] w_sum;

  // Stride never exceeds RADIX, so a single wrap is always enough.
  assign w_sum   = SUM_W'(digit_i) + SUM_W'(addend_i) + SUM_W'(carry_i);
  assign carry_o = (w_sum >= SUM_W'(RADIX));
  assign digit_o = carry_o ? DIGIT_W'(w_sum - SUM_W'(RADIX)) : DIGIT_W'(w_sum);

endmodule

`default_nettype wire

// File: rtl/md5_guess_generator.sv
// ----------------------------------------------------------------------------
// md5_guess_generator: bijective base-26 candidate producer on a valid/ready
// guess interface. Define GUESS_COUNT_EN to implement guess_count. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module md5_guess_generator #(
  parameter int         MAX_LEN  = 5,
  parameter logic [7:0] CHAR_MIN = 8'h61,
  parameter logic [7:0] CHAR_MAX = 8'h7A
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic [7:0]                         start_char,
  input  logic [md5_pkg::STRIDE_W-1:0]       increment,
  input  logic                               guess_ready,
  output logic                               guess_valid,
  output logic [md5_pkg::GUESS_DATA_W-1:0]   guess_data,
  output logic [md5_pkg::GUESS_LEN_W-1:0]    guess_len,
  output logic                               busy,
  output logic                               exhausted,
  output logic [md5_pkg::GUESS_COUNT_W-1:0]  guess_count
);

  import md5_pkg::*;

  localparam int ALPHA_RADIX = int'(CHAR_MAX) - int'(CHAR_MIN) + 1;
  localparam int DIGIT_W     = (ALPHA_RADIX > 2) ? $clog2(ALPHA_RADIX) : 1;

  state_e                   state_q, state_d;
  logic [DIGIT_W-1:0]       dig_q [MAX_LEN];
  logic [DIGIT_W-1:0]       dig_d [MAX_LEN];
  logic [DIGIT_W-1:0]       w_dsum [MAX_LEN];
  logic [MAX_LEN:0]         w_carry;
  logic [GUESS_LEN_W-1:0]   len_q, len_d;
  logic [STRIDE_W-1:0]      stride_q, stride_d;
  logic                     valid_q, valid_d;
  logic                     exh_q, exh_d;
  logic                     w_xfer, w_load, w_top_carry, w_start_ok;
  logic [GUESS_DATA_W-1:0]  w_data;

  assign w_xfer     = valid_q & guess_ready;
  assign w_load     = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign w_start_ok = (start_char >= CHAR_MIN) && (start_char <= CHAR_MAX);
  assign w_carry[0] = 1'b0;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_digit
    guess_digit_add #(
      .DIGIT_W (DIGIT_W),
      .RADIX   (ALPHA_RADIX),
      .ADD_W   (STRIDE_W)
    ) u_add (
      .digit_i  (dig_q[gi]),
      .addend_i ((gi == 0) ? stride_q : '0),
      .carry_i  (w_carry[gi]),
      .digit_o  (w_dsum[gi]),
      .carry_o  (w_carry[gi+1])
    );
  end

  // Carry out of the most significant live digit, d[len-1].
  always_comb begin
    w_top_carry = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (len_q == GUESS_LEN_W'(i + 1)) w_top_carry = w_carry[i+1];
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    stride_d = stride_q;
    valid_d  = valid_q;
    exh_d    = exh_q;
    for (int i = 0; i < MAX_LEN; i++) dig_d[i] = dig_q[i];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (w_load) begin
          state_d  = ST_RUN;
          valid_d  = 1'b1;
          exh_d    = 1'b0;
          len_d    = GUESS_LEN_W'(1);
          stride_d = (increment == '0) ? STRIDE_W'(1) : increment;
          for (int i = 0; i < MAX_LEN; i++) dig_d[i] = '0;
          dig_d[0] = w_start_ok ? DIGIT_W'(start_char - CHAR_MIN) : '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DONE;
          valid_d = 1'b0;
        end else if (w_xfer) begin
          if (w_top_carry && (len_q == GUESS_LEN_W'(MAX_LEN))) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            exh_d   = 1'b1;
          end else begin
            // Digits at or above len stay zero, so a new leading digit is "a".
            for (int i = 0; i < MAX_LEN; i++) begin
              dig_d[i] = (GUESS_LEN_W'(i) < len_q) ? w_dsum[i] : '0;
            end
            if (w_top_carry) len_d = len_q + GUESS_LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      stride_q <= '0;
      valid_q  <= 1'b0;
      exh_q    <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) dig_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      valid_q  <= valid_d;
      exh_q    <= exh_d;
      for (int i = 0; i < MAX_LEN; i++) dig_q[i] <= dig_d[i];
    end
  end

  // Right-aligned digits are emitted left-justified, first char in the MSB.
  always_comb begin
    w_data = '0;
    for (int p = 0; p < MAX_LEN; p++) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if ((p < int'(len_q)) && (k == int'(len_q) - 1 - p)) begin
          w_data[GUESS_DATA_W-1-8*p -: 8] = CHAR_MIN + 8'(dig_q[k]);
        end
      end
    end
  end

`ifdef GUESS_COUNT_EN
  logic [GUESS_COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (w_load) begin
      count_d = '0;
    end else if (w_xfer && (count_q != '1)) begin
      count_d = count_q + GUESS_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign guess_count = count_q;
`else
  assign guess_count = '0;
`endif

  assign guess_valid = valid_q;
  assign guess_data  = w_data;
  assign guess_len   = len_q;
  assign busy        = (state_q == ST_RUN);
  assign exhausted   = exh_q;

endmodule

`default_nettype wire

// File: tb/tb_md5_guess_generator.sv
// ----------------------------------------------------------------------------
// tb_md5_guess_generator: directed vectors for md5_guess_generator. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_md5_guess_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start, stop, ready;
  logic [7:0]   start_char;
  logic [2:0]   increment;
  logic         valid, busy, exh;
  logic [127:0] data;
  logic [4:0]   len;
  logic [31:0]  cnt;

  logic         b_start, b_stop, b_ready;
  logic [7:0]   b_start_char;
  logic [2:0]   b_increment;
  logic         b_valid, b_busy, b_exh;
  logic [127:0] b_data;
  logic [4:0]   b_len;
  logic [31:0]  b_cnt;

  md5_guess_generator #(.MAX_LEN(5)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_char(start_char), .increment(increment), .guess_ready(ready),
    .guess_valid(valid), .guess_data(data), .guess_len(len),
    .busy(busy), .exhausted(exh), .guess_count(cnt)
  );

  md5_guess_generator #(.MAX_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop),
    .start_char(b_start_char), .increment(b_increment), .guess_ready(b_ready),
    .guess_valid(b_valid), .guess_data(b_data), .guess_len(b_len),
    .busy(b_busy), .exhausted(b_exh), .guess_count(b_cnt)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [127:0] mk(input string s);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < s.len(); i++) d[127-8*i -: 8] = s[i];
    return d;
  endfunction

  function automatic logic [31:0] ecnt(input int n);
`ifdef GUESS_COUNT_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]   sc;
    logic [2:0]   inc;
    int           n;
    logic [127:0] data;
    logic [4:0]   len;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  initial begin
    int k;

    vecs[0]  = '{8'h61, 3'd1, 0,   mk("a"),   5'd1};
    vecs[1]  = '{8'h61, 3'd1, 25,  mk("z"),   5'd1};
    vecs[2]  = '{8'h61, 3'd1, 26,  mk("aa"),  5'd2};
    vecs[3]  = '{8'h61, 3'd1, 27,  mk("ab"),  5'd2};
    vecs[4]  = '{8'h79, 3'd3, 1,   mk("ab"),  5'd2};
    vecs[5]  = '{8'h79, 3'd3, 2,   mk("ae"),  5'd2};
    vecs[6]  = '{8'h61, 3'd0, 2,   mk("c"),   5'd1};
    vecs[7]  = '{8'h41, 3'd1, 0,   mk("a"),   5'd1};
    vecs[8]  = '{8'h7A, 3'd7, 1,   mk("ag"),  5'd2};
    vecs[9]  = '{8'h63, 3'd5, 5,   mk("ab"),  5'd2};
    vecs[10] = '{8'h61, 3'd1, 702, mk("aaa"), 5'd3};
    vecs[11] = '{8'h6D, 3'd2, 20,  mk("ba"),  5'd2};
    vecs[12] = '{8'h7B, 3'd1, 1,   mk("b"),   5'd1};

    start = 0; stop = 0; ready = 0; start_char = 0; increment = 0;
    b_start = 0; b_stop = 0; b_ready = 0; b_start_char = 0; b_increment = 0;
    reset = 1;
    step();
    step();
    chk("reset valid", valid, 0);
    chk("reset data", data, 0);
    chk("reset len", len, 0);
    chk("reset busy", busy, 0);
    chk("reset exhausted", exh, 0);
    chk("reset count", cnt, 0);
    chk("reset dut2 valid", b_valid, 0);
    reset = 0;
    step();

    for (int v = 0; v < NVEC; v++) begin
      start = 1; start_char = vecs[v].sc; increment = vecs[v].inc; ready = 0;
      step();
      start = 0; start_char = 8'h00; increment = 3'd6;
      chk($sformatf("vec%0d busy", v), busy, 1);
      ready = 1;
      repeat (vecs[v].n) step();
      ready = 0;
      chk($sformatf("vec%0d data", v), data, vecs[v].data);
      chk($sformatf("vec%0d len", v), len, vecs[v].len);
      chk($sformatf("vec%0d valid", v), valid, 1);
      chk($sformatf("vec%0d count", v), cnt, ecnt(vecs[v].n));
      stop = 1;
      step();
      stop = 0;
      chk($sformatf("vec%0d stop valid", v), valid, 0);
      chk($sformatf("vec%0d stop busy", v), busy, 0);
    end

    // Backpressure: candidate held while ready is low.
    start = 1; start_char = 8'h61; increment = 3'd1; ready = 0;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall data", data, mk("a"));
      chk("stall len", len, 1);
      chk("stall count", cnt, ecnt(0));
    end
    ready = 1;
    step();
    chk("after stall data", data, mk("b"));
    chk("after stall count", cnt, ecnt(1));

    // start during RUN is ignored.
    start = 1; start_char = 8'h6D;
    step();
    start = 0;
    chk("start in run data", data, mk("c"));
    chk("start in run count", cnt, ecnt(2));

    // stop with a same-cycle transfer on "c"; stop beats start.
    stop = 1; start = 1;
    step();
    stop = 0; start = 0; ready = 0;
    chk("stop valid", valid, 0);
    chk("stop busy", busy, 0);
    chk("stop counted", cnt, ecnt(3));
    step();
    chk("done holds", busy, 0);

    start = 1; start_char = 8'h61;
    step();
    start = 0;
    chk("restart data", data, mk("a"));
    chk("restart count", cnt, ecnt(0));
    chk("restart exhausted", exh, 0);
    chk("restart valid", valid, 1);

    // Reset mid-run.
    ready = 1;
    step();
    step();
    chk("pre-reset data", data, mk("c"));
    reset = 1; ready = 0;
    step();
    chk("midreset valid", valid, 0);
    chk("midreset data", data, 0);
    chk("midreset len", len, 0);
    chk("midreset count", cnt, 0);
    chk("midreset busy", busy, 0);
    reset = 0;
    step();
    chk("post reset idle", valid, 0);

    // Keyspace exhaustion at MAX_LEN=2.
    b_start = 1; b_start_char = 8'h61; b_increment = 3'd1;
    step();
    b_start = 0; b_ready = 1;
    k = 0;
    while (b_data !== mk("zy") && k < 1000) begin
      step();
      k++;
    end
    chk("zy reached at", 128'(k), 128'(700));
    step();
    chk("zz data", b_data, mk("zz"));
    chk("zz valid", b_valid, 1);
    step();
    chk("overflow valid", b_valid, 0);
    chk("overflow exhausted", b_exh, 1);
    chk("overflow busy", b_busy, 0);
    chk("overflow count", b_cnt, ecnt(702));
    b_ready = 0; b_stop = 1;
    step();
    b_stop = 0;
    chk("exhausted sticky", b_exh, 1);
    chk("stop in done", b_busy, 0);
    b_start = 1;
    step();
    b_start = 0;
    chk("dut2 restart exhausted", b_exh, 0);
    chk("dut2 restart data", b_data, mk("a"));
    chk("dut2 restart count", b_cnt, ecnt(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
